// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC channel scheduler: FSM states,
// channel-index width and the round-robin next-channel search.
package adc_sched_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CAPTURE
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit strictly above cur, wrapping to bit 0; cur = -1 gives the lowest set bit.
  function automatic int next_channel(input logic [MAX_CH-1:0] mask, input int cur);
    int   nxt;
    logic found;
    nxt   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++)
      if (!found && i > cur && mask[i]) begin
        nxt   = i;
        found = 1'b1;
      end
    for (int i = 0; i < MAX_CH; i++)
      if (!found && mask[i]) begin
        nxt   = i;
        found = 1'b1;
      end
    return nxt;
  endfunction

endpackage

// File: rtl/adc_sched_accum.sv
// Per-dwell accumulator: sums the captured samples and presents the floor
// average including the sample being added this cycle.
module adc_sched_accum
  import adc_sched_pkg::*;
#(
  parameter int ADC_BITLEN   = 24,
  parameter int SIGNED_INPUT = 1,
  parameter int LOG2         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  add,
  input  logic [ADC_BITLEN-1:0] sample,
  output logic [ADC_BITLEN-1:0] avg
);

  localparam int ACC_W = ADC_BITLEN + LOG2;

  logic [ACC_W-1:0] acc_q, acc_d, sample_ext, sum;

  always_comb begin
    if (SIGNED_INPUT != 0) sample_ext = ACC_W'($signed(sample));
    else                   sample_ext = ACC_W'(sample);
    sum = acc_q + sample_ext;
    // Arithmetic shift floors toward minus infinity for negative sums.
    if (SIGNED_INPUT != 0) avg = ADC_BITLEN'($signed(sum) >>> LOG2);
    else                   avg = ADC_BITLEN'(sum >> LOG2);
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (add) acc_d = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Time-shares one sigma-delta ADC across muxed inputs: settle, capture, tag.
// Define ADC_SCHED_AVG_EN to emit one averaged result per dwell instead of every capture.
module adc_channel_scheduler
  import adc_sched_pkg::*;
#(
  parameter int  NUM_CHANNELS        = 4,
  parameter int  ADC_BITLEN          = 24,
  parameter int  SIGNED_INPUT        = 1,
  parameter int  SETTLE_SAMPLES      = 2,
  parameter int  LOG2_SAMPLES_PER_CH = 2,
  localparam int CH_W                = ch_w(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  input  logic [ADC_BITLEN-1:0]   adc_output,
  input  logic                    adc_valid,
  output logic [CH_W-1:0]         mux_sel,
  output logic [ADC_BITLEN-1:0]   out_data,
  output logic [CH_W-1:0]         out_channel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int CAP_N   = 1 << LOG2_SAMPLES_PER_CH;
  localparam int CNT_MAX = (SETTLE_SAMPLES > CAP_N) ? SETTLE_SAMPLES : CAP_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CAP_LAST    = CNT_W'(CAP_N - 1);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         mux_sel_q, mux_sel_d, nxt_ch_q, nxt_ch_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADC_BITLEN-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]         out_channel_q, out_channel_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    enable_q, enable_d;
  logic                    capture, dwell_done, res_vld;
  logic [ADC_BITLEN-1:0]   res_data;

  always_comb begin
    state_d    = state_q;
    mux_sel_d  = mux_sel_q;
    nxt_ch_d   = nxt_ch_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    dwell_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (chan_mask != '0) begin
          nxt_ch_d = CH_W'(next_channel(MAX_CH'(chan_mask), -1));
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        mux_sel_d = nxt_ch_q;
        cnt_d     = '0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (adc_valid) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (adc_valid) begin
          capture = 1'b1;
          if (cnt_q == CAP_LAST) begin
            dwell_done = 1'b1;
            cnt_d      = '0;
            // The mask is re-sampled only here, at the end of a dwell.
            if (chan_mask == '0) begin
              state_d = ST_IDLE;
            end else begin
              nxt_ch_d = CH_W'(next_channel(MAX_CH'(chan_mask), int'(mux_sel_q)));
              state_d  = ST_SELECT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      capture    = 1'b0;
      dwell_done = 1'b0;
    end
  end

`ifdef ADC_SCHED_AVG_EN
  logic [ADC_BITLEN-1:0] avg_data;

  adc_sched_accum #(
    .ADC_BITLEN  (ADC_BITLEN),
    .SIGNED_INPUT(SIGNED_INPUT),
    .LOG2        (LOG2_SAMPLES_PER_CH)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == ST_SELECT),
    .add   (capture),
    .sample(adc_output),
    .avg   (avg_data)
  );

  assign res_vld  = dwell_done;
  assign res_data = avg_data;
`else
  assign res_vld  = capture;
  assign res_data = adc_output;
`endif

  always_comb begin
    enable_d      = enable;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    overrun_d     = overrun_q;
    if (enable && !enable_q) overrun_d = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (res_vld) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_valid_d   = 1'b1;
        out_data_d    = res_data;
        out_channel_d = mux_sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mux_sel_q     <= '0;
      nxt_ch_q      <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      enable_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mux_sel_q     <= mux_sel_d;
      nxt_ch_q      <= nxt_ch_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
      enable_q      <= enable_d;
    end
  end

  assign mux_sel     = mux_sel_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/adc_channel_scheduler.md
# adc_channel_scheduler

Time-shares one `sigma_delta_adc` between up to `NUM_CHANNELS` analog inputs routed through an external analog mux. It drives the mux select and discards the samples corrupted by CIC filter memory after each switch. It then captures a fixed number of decimated samples per channel and emits channel-tagged results on a valid/ready stream. It sits between the ADC's `adc_output`/`adc_valid` and downstream sample consumers.

## Interface
- `NUM_CHANNELS`, 4: analog inputs scheduled, 2..16
- `ADC_BITLEN`, 24: sample width, matches ADC
- `SIGNED_INPUT`, 1: 1 = `adc_output` is two's complement, 0 = unsigned
- `SETTLE_SAMPLES`, 2: `adc_valid` pulses discarded after each switch, must be ≥ ADC `CIC_STAGES`
- `LOG2_SAMPLES_PER_CH`, 2: captures per channel dwell = 2**N
- `clk` in 1: ADC bit clock; the single clock
- `rst` in 1: synchronous, active-high reset
- `enable` in 1: run scheduling while high
- `chan_mask` in NUM_CHANNELS: bit i = channel i participates
- `adc_output` in ADC_BITLEN: decimated ADC sample
- `adc_valid` in 1: one-cycle strobe per sample
- `mux_sel` out CH_W (= max(1,$clog2(NUM_CHANNELS))): external mux select
- `out_data` out ADC_BITLEN: result sample
- `out_channel` out CH_W: channel of `out_data`
- `out_valid` out 1: result available
- `out_ready` in 1: downstream accepts
- `busy` out 1: FSM not in IDLE
- `overrun` out 1: sticky, a result was dropped

## Operation
- FSM states: IDLE, SELECT, SETTLE, CAPTURE.
- IDLE -> SELECT when `enable`=1 and `chan_mask`≠0. The first channel is the lowest set bit.
- SELECT (exactly 1 cycle): register `mux_sel` to the chosen channel, clear counters, go to SETTLE. `adc_valid` is ignored in SELECT.
- SETTLE: count `adc_valid` and discard the sample. After `SETTLE_SAMPLES` pulses go to CAPTURE.
- CAPTURE: each `adc_valid` is a capture. After 2**LOG2 captures, choose the next channel and go to SELECT.
- Next channel: lowest set bit of `chan_mask` above the current index, wrapping to bit 0. `chan_mask` is sampled only at this decision. If the mask is now 0, go to IDLE.
- If `mux_sel` is unchanged (single enabled channel), SELECT and SETTLE still execute.
- `enable` low in any state: go to IDLE next cycle and abandon the partial dwell. The output register is kept until consumed.
- Output register is single-entry:
  - A new result while `out_valid`=1 and no transfer that cycle is dropped, and `overrun` is set.
  - Transfer plus new result in the same cycle: the new result is loaded and there is no overrun.
- `overrun` clears on `rst` or on a rising edge of `enable`.
- Reset values: `mux_sel`=0, `out_data`=0, `out_channel`=0, `out_valid`=0, `busy`=0, `overrun`=0, state IDLE, counters 0.

## Timing
- `out_valid` rises the cycle after the producing `adc_valid`. `out_data` and `out_channel` are registered together.
- While `out_valid` is high and `out_ready` is low, `out_data` and `out_channel` are stable. Transfer happens on `out_valid`&&`out_ready`.
- `mux_sel` changes on the clock edge that leaves SELECT.
- Dwell per channel is 1 clk + (SETTLE_SAMPLES + 2**LOG2) ADC sample periods. With defaults and OSR 256 that is 1 + 6·256 clocks.
- `adc_valid` arriving on the same cycle as a state transition is counted by the state being exited, except in SELECT.

## Configuration
- `ADC_SCHED_AVG_EN` defined:
  - CAPTURE accumulates the 2**LOG2 samples in an ADC_BITLEN+LOG2 bit accumulator, sign-extended when SIGNED_INPUT.
  - Emits one result per dwell: accumulator shifted right by LOG2, arithmetic when signed, truncating toward −∞.
- Undefined: every captured sample is emitted directly, giving 2**LOG2 results per dwell, each tagged with the current channel.

## Structure
- `adc_sched_pkg` holds:
  - the state enum typedef
  - a CH_W width function
  - a `next_channel(mask, cur)` function shared by RTL and bench model
- Sub-module `adc_sched_accum`: accumulate, clear and average datapath, instantiated only under `ADC_SCHED_AVG_EN`.

## Test plan
- Mask 4'b1011, `out_ready`=1, defaults: `mux_sel` sequence 0,1,3,0. Exactly 2 discards per switch; `out_channel` matches the captured mux.
- Constant input 0x000100 on ch0, 0x000300 on ch1, AVG_EN on: outputs alternate 0x000100 and 0x000300. Samples −1,−2,−2,−2 average to −2.
- `out_ready` held low across two results: first result is retained unchanged, `overrun`=1. `overrun` clears after an `enable` 0→1.
- `enable` dropped mid-CAPTURE: IDLE next cycle, no partial result, pending result still handshakes out.
- `rst` asserted mid-SETTLE with `out_valid`=1: all outputs return to reset values the following cycle.
- Mask changed from 4'b0001 to 0 during a dwell: current dwell completes, then IDLE and `busy`=0.
